// File: rtl/alu_flag_unit.sv
// Registered Z80 flag register (F) with optional F' shadow.
// Computes S/Z/H/PV/N/C and the undocumented X bits for 8- or 16-bit ALU ops.
module alu_flag_unit #(
    parameter int         alu_width   = 8,
    parameter bit         shadow_en   = 1'b1,
    parameter logic [7:0] reset_flags = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [3:0]           opcode,
    input  logic                 op_sign,
    input  logic                 use_carry,
    input  logic [alu_width-1:0] a,
    input  logic [alu_width-1:0] b,
    input  logic [alu_width-1:0] op_result,
    input  logic                 carry_out,
    input  logic                 half_set,
    input  logic [7:0]           flag_mask,
    input  logic [7:0]           load_data,
    output logic [7:0]           f_out,
    output logic                 carry_flag,
    output logic                 flags_valid
);

    localparam int MSB = alu_width - 1;
    localparam int HB  = alu_width / 2 - 1;

    localparam logic [3:0] OP_NUMERIC  = 4'd0;
    localparam logic [3:0] OP_SHIFT    = 4'd1;
    localparam logic [3:0] OP_LOGIC    = 4'd2;
    localparam logic [3:0] OP_SCF      = 4'd3;
    localparam logic [3:0] OP_CCF      = 4'd4;
    localparam logic [3:0] OP_LOAD     = 4'd5;
    localparam logic [3:0] OP_EXCHANGE = 4'd6;

    // H is the carry/borrow out of the low half, including the carry-in.
    function automatic logic half_carry(input logic [HB:0] x, input logic [HB:0] y,
                                        input logic sub, input logic cin);
        logic [HB+1:0] ci;
        logic [HB+1:0] s;
        ci = {{(HB+1){1'b0}}, cin};
        s  = sub ? ({1'b0, x} - {1'b0, y} - ci) : ({1'b0, x} + {1'b0, y} + ci);
        return s[HB+1];
    endfunction

    function automatic logic overflow(input logic sa, input logic sb, input logic sr,
                                      input logic sub);
        return sub ? ((sa & ~sb & ~sr) | (~sa & sb & sr))
                   : ((sa & sb & ~sr) | (~sa & ~sb & sr));
    endfunction

    function automatic logic even_parity(input logic [7:0] x);
        return ~^x;
    endfunction

    logic [7:0] f_q, f_d;
    logic [7:0] f_shadow_q, f_shadow_d;
    logic       flags_valid_q, flags_valid_d;

    logic       cin;
    logic       res_s, res_z, res_x5, res_x3, res_par;
    logic [7:0] numeric_flags, shift_flags, logic_flags;
    logic       unused_ops;

    assign cin     = use_carry & f_q[0];
    assign res_s   = op_result[MSB];
    assign res_z   = (op_result == '0);
    assign res_x5  = op_result[5];
    assign res_x3  = op_result[3];
    assign res_par = even_parity(op_result[7:0]);

    assign numeric_flags = {res_s, res_z, res_x5,
                            half_carry(a[HB:0], b[HB:0], op_sign, cin),
                            res_x3,
                            overflow(a[MSB], b[MSB], op_result[MSB], op_sign),
                            op_sign, carry_out};
    assign shift_flags   = {res_s, res_z, res_x5, 1'b0, res_x3, res_par, 1'b0, carry_out};
    assign logic_flags   = {res_s, res_z, res_x5, half_set, res_x3, res_par, 1'b0, 1'b0};

    // Middle operand bits only matter to the ALU itself, not to the flags.
    assign unused_ops = ^{a[MSB-1:HB+1], b[MSB-1:HB+1]};

    always_comb begin
        f_d           = f_q;
        f_shadow_d    = f_shadow_q;
        flags_valid_d = 1'b0;
        if (valid) begin
            flags_valid_d = 1'b1;
            case (opcode)
                OP_NUMERIC:  f_d = (f_q & ~flag_mask) | (numeric_flags & flag_mask);
                OP_SHIFT:    f_d = (f_q & ~flag_mask) | (shift_flags & flag_mask);
                OP_LOGIC:    f_d = (f_q & ~flag_mask) | (logic_flags & flag_mask);
                OP_SCF:      f_d = {f_q[7:5], 1'b0, f_q[3:2], 1'b0, 1'b1};
                OP_CCF:      f_d = {f_q[7:5], f_q[0], f_q[3:2], 1'b0, ~f_q[0]};
                OP_LOAD:     f_d = load_data;
                OP_EXCHANGE: begin
                    if (shadow_en) begin
                        f_d        = f_shadow_q;
                        f_shadow_d = f_q;
                    end
                end
                default:     f_d = f_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_q           <= reset_flags;
            f_shadow_q    <= reset_flags;
            flags_valid_q <= 1'b0;
        end else begin
            f_q           <= f_d;
            f_shadow_q    <= f_shadow_d;
            flags_valid_q <= flags_valid_d;
        end
    end

    assign f_out       = f_q;
    assign carry_flag  = f_q[0];
    assign flags_valid = flags_valid_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Bench for alu_flag_unit: 8-bit and 16-bit instances driven in lockstep,
// checked against directed constants and an arithmetic reference model.
module tb_alu_flag_unit;

    logic        clk = 1'b0;
    logic        reset, valid, op_sign, use_carry, half_set;
    logic [3:0]  opcode;
    logic [7:0]  flag_mask, load_data;
    logic [7:0]  a8, b8, r8;
    logic [15:0] a16, b16, r16;
    logic        co8, co16;
    logic [7:0]  f8, f16;
    logic        cf8, cf16, fv8, fv16;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mf8, ms8, mf16, ms16;
    logic       mvalid;

    always #5 clk = ~clk;

    alu_flag_unit #(.alu_width(8), .shadow_en(1'b1), .reset_flags(8'hFF)) dut8 (
        .clk(clk), .reset(reset), .valid(valid), .opcode(opcode), .op_sign(op_sign),
        .use_carry(use_carry), .a(a8), .b(b8), .op_result(r8), .carry_out(co8),
        .half_set(half_set), .flag_mask(flag_mask), .load_data(load_data),
        .f_out(f8), .carry_flag(cf8), .flags_valid(fv8));

    alu_flag_unit #(.alu_width(16), .shadow_en(1'b1), .reset_flags(8'hFF)) dut16 (
        .clk(clk), .reset(reset), .valid(valid), .opcode(opcode), .op_sign(op_sign),
        .use_carry(use_carry), .a(a16), .b(b16), .op_result(r16), .carry_out(co16),
        .half_set(half_set), .flag_mask(flag_mask), .load_data(load_data),
        .f_out(f16), .carry_flag(cf16), .flags_valid(fv16));

    // Reference: flags derived from integer arithmetic on the operands.
    function automatic logic [7:0] model_f(input int w, input logic [7:0] f,
                                           input logic [3:0] op, input logic sg,
                                           input logic uc, input int a, input int b,
                                           input int r, input logic co, input logic hs,
                                           input logic [7:0] mask, input logic [7:0] ld);
        int half, lo_a, lo_b, sa, sb, tru, cin;
        logic s, z, x5, x3, h, pv, par;
        logic [7:0] calc;
        half = 1 << (w / 2);
        cin  = (uc && f[0]) ? 1 : 0;
        s    = ((r >> (w - 1)) & 1) == 1;
        z    = (r == 0);
        x5   = ((r >> 5) & 1) == 1;
        x3   = ((r >> 3) & 1) == 1;
        par  = ($countones(r & 8'hFF) % 2) == 0;
        lo_a = a % half;
        lo_b = b % half;
        sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        tru  = sg ? sa - sb - cin : sa + sb + cin;
        pv   = (tru > (1 << (w - 1)) - 1) || (tru < -(1 << (w - 1)));
        h    = sg ? (lo_a < lo_b + cin) : (lo_a + lo_b + cin >= half);
        case (op)
            4'd0: calc = {s, z, x5, h, x3, pv, sg, co};
            4'd1: calc = {s, z, x5, 1'b0, x3, par, 1'b0, co};
            4'd2: calc = {s, z, x5, hs, x3, par, 1'b0, 1'b0};
            default: calc = 8'h00;
        endcase
        case (op)
            4'd0, 4'd1, 4'd2: return (f & ~mask) | (calc & mask);
            4'd3: return {f[7:5], 1'b0, f[3:2], 1'b0, 1'b1};
            4'd4: return {f[7:5], f[0], f[3:2], 1'b0, ~f[0]};
            4'd5: return ld;
            default: return f;
        endcase
    endfunction

    task automatic tick();
        logic [7:0] t;
        if (reset) begin
            mf8 = 8'hFF; ms8 = 8'hFF; mf16 = 8'hFF; ms16 = 8'hFF;
            mvalid = 1'b0;
        end else if (valid) begin
            mvalid = 1'b1;
            if (opcode == 4'd6) begin
                t = mf8;  mf8 = ms8;  ms8 = t;
                t = mf16; mf16 = ms16; ms16 = t;
            end else begin
                mf8  = model_f(8, mf8, opcode, op_sign, use_carry, int'(a8), int'(b8),
                               int'(r8), co8, half_set, flag_mask, load_data);
                mf16 = model_f(16, mf16, opcode, op_sign, use_carry, int'(a16), int'(b16),
                               int'(r16), co16, half_set, flag_mask, load_data);
            end
        end else begin
            mvalid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Behaves like the ALU: result and carry consistent with operands and carry-in.
    task automatic gen_numeric(input logic sub);
        int full, cin;
        cin  = (use_carry && mf8[0]) ? 1 : 0;
        full = sub ? int'(a8) - int'(b8) - cin : int'(a8) + int'(b8) + cin;
        r8   = full[7:0];
        co8  = sub ? (full < 0) : full[8];
        cin  = (use_carry && mf16[0]) ? 1 : 0;
        full = sub ? int'(a16) - int'(b16) - cin : int'(a16) + int'(b16) + cin;
        r16  = full[15:0];
        co16 = sub ? (full < 0) : full[16];
    endtask

    task automatic set_op(input logic [3:0] op, input logic [7:0] mask);
        valid = 1'b1; opcode = op; flag_mask = mask;
        op_sign = 1'b0; use_carry = 1'b0; half_set = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid = 1'b0;
        tick(); tick();
        n_cmp++; if (f8 !== 8'hFF) begin n_bad++; $display("FAIL reset_f8 got %h want ff", f8); end
        n_cmp++; if (f16 !== 8'hFF) begin n_bad++; $display("FAIL reset_f16 got %h want ff", f16); end
        n_cmp++; if (fv8 !== 1'b0 || fv16 !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b%b want 00", fv8, fv16); end
        reset = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (f8 !== 8'hFF || f16 !== 8'hFF) begin n_bad++; $display("FAIL idle_hold got %h/%h want ff/ff", f8, f16); end
        n_cmp++; if (fv8 !== 1'b0) begin n_bad++; $display("FAIL idle_valid got %b want 0", fv8); end
    endtask

    task automatic test_numeric();
        set_op(4'd0, 8'hFF);
        a8 = 8'h7F; b8 = 8'h01; r8 = 8'h80; co8 = 1'b0;
        a16 = 16'h7FFF; b16 = 16'h0001; r16 = 16'h8000; co16 = 1'b0;
        tick();
        n_cmp++; if (f8 !== 8'h94) begin n_bad++; $display("FAIL add8_overflow got %h want 94", f8); end
        n_cmp++; if (f16 !== 8'h94) begin n_bad++; $display("FAIL add16_overflow got %h want 94", f16); end
        n_cmp++; if (fv8 !== 1'b1 || fv16 !== 1'b1) begin n_bad++; $display("FAIL add_valid got %b%b want 11", fv8, fv16); end
        set_op(4'd5, 8'h00); load_data = 8'hFF;
        tick();
        set_op(4'd0, 8'h3B); use_carry = 1'b1;
        a8 = 8'h0F; b8 = 8'h00; r8 = 8'h10; co8 = 1'b0;
        a16 = 16'h0FFF; b16 = 16'h0000; r16 = 16'h1000; co16 = 1'b0;
        tick();
        n_cmp++; if (f16 !== 8'hD4) begin n_bad++; $display("FAIL adc16_masked got %h want d4", f16); end
        n_cmp++; if (f8 !== 8'hD4) begin n_bad++; $display("FAIL adc8_masked got %h want d4", f8); end
        n_cmp++; if (cf16 !== 1'b0) begin n_bad++; $display("FAIL adc16_carry got %b want 0", cf16); end
        set_op(4'd0, 8'hFF); op_sign = 1'b1;
        a8 = 8'h80; b8 = 8'h01; r8 = 8'h7F; co8 = 1'b0;
        a16 = 16'h8000; b16 = 16'h0001; r16 = 16'h7FFF; co16 = 1'b0;
        tick();
        n_cmp++; if (f8 !== 8'h3E) begin n_bad++; $display("FAIL sub8_overflow got %h want 3e", f8); end
        n_cmp++; if (f16 !== 8'h3E) begin n_bad++; $display("FAIL sub16_overflow got %h want 3e", f16); end
        set_op(4'd0, 8'h00); r8 = 8'h00; r16 = 16'h0000; co8 = 1'b1; co16 = 1'b1;
        tick();
        n_cmp++; if (f8 !== 8'h3E || fv8 !== 1'b1) begin n_bad++; $display("FAIL mask_zero got %h/%b want 3e/1", f8, fv8); end
        set_op(4'd9, 8'hFF);
        tick();
        n_cmp++; if (f8 !== 8'h3E || fv8 !== 1'b1) begin n_bad++; $display("FAIL undef_op got %h/%b want 3e/1", f8, fv8); end
        valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        set_op(4'd5, 8'h00); load_data = 8'h01;
        tick();
        n_cmp++; if (f8 !== 8'h01 || cf8 !== 1'b1) begin n_bad++; $display("FAIL load_01 got %h/%b want 01/1", f8, cf8); end
        set_op(4'd4, 8'h00);
        tick();
        n_cmp++; if (f8 !== 8'h10 || f16 !== 8'h10) begin n_bad++; $display("FAIL ccf got %h/%h want 10/10", f8, f16); end
        set_op(4'd3, 8'h00);
        tick();
        n_cmp++; if (f8 !== 8'h01 || fv8 !== 1'b1) begin n_bad++; $display("FAIL scf got %h/%b want 01/1", f8, fv8); end
        valid = 1'b0;
        tick();
        n_cmp++; if (fv8 !== 1'b0 || f8 !== 8'h01) begin n_bad++; $display("FAIL pulse_end got %b/%h want 0/01", fv8, f8); end
    endtask

    task automatic test_exchange();
        set_op(4'd5, 8'h00); load_data = 8'h42;
        tick();
        set_op(4'd6, 8'h00);
        tick();
        n_cmp++; if (f8 !== 8'hFF || f16 !== 8'hFF) begin n_bad++; $display("FAIL exx1 got %h/%h want ff/ff", f8, f16); end
        tick();
        n_cmp++; if (f8 !== 8'h42 || f16 !== 8'h42) begin n_bad++; $display("FAIL exx2 got %h/%h want 42/42", f8, f16); end
        set_op(4'd5, 8'h00); load_data = 8'h00; reset = 1'b1;
        tick();
        n_cmp++; if (f8 !== 8'hFF || fv8 !== 1'b0) begin n_bad++; $display("FAIL reset_vs_valid got %h/%b want ff/0", f8, fv8); end
        reset = 1'b0; set_op(4'd6, 8'h00);
        tick();
        n_cmp++; if (f8 !== 8'hFF) begin n_bad++; $display("FAIL shadow_reset got %h want ff", f8); end
        valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int k;
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 12);
            valid     = ($urandom_range(0, 7) != 0);
            opcode    = (k < 4) ? 4'd0 : (k < 6) ? 4'd1 : (k < 8) ? 4'd2 :
                        (k == 12) ? 4'(9 + $urandom_range(0, 6)) : 4'(k - 5);
            op_sign   = 1'($urandom);
            use_carry = 1'($urandom);
            half_set  = 1'($urandom);
            flag_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            load_data = 8'($urandom);
            a8 = 8'($urandom);  b8 = 8'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom);
            if (($urandom_range(0, 5)) == 0) begin a8 = 8'h80; b8 = 8'h80; a16 = 16'h8000; b16 = 16'h8000; end
            if (opcode == 4'd0) gen_numeric(op_sign);
            else begin
                r8 = 8'($urandom); r16 = 16'($urandom); co8 = 1'($urandom); co16 = 1'($urandom);
                if (($urandom_range(0, 7)) == 0) begin r8 = 8'h00; r16 = 16'h0000; end
            end
            tick();
            n_cmp++; if (f8 !== mf8) begin n_bad++; $display("FAIL rnd_f8 i=%0d op=%0d got %h want %h", i, opcode, f8, mf8); end
            n_cmp++; if (f16 !== mf16) begin n_bad++; $display("FAIL rnd_f16 i=%0d op=%0d got %h want %h", i, opcode, f16, mf16); end
            n_cmp++; if (fv8 !== mvalid || fv16 !== mvalid) begin n_bad++; $display("FAIL rnd_valid i=%0d got %b%b want %b", i, fv8, fv16, mvalid); end
            n_cmp++; if (cf8 !== mf8[0] || cf16 !== mf16[0]) begin n_bad++; $display("FAIL rnd_carry i=%0d got %b%b want %b%b", i, cf8, cf16, mf8[0], mf16[0]); end
        end
        valid = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; opcode = 4'd0; op_sign = 1'b0; use_carry = 1'b0;
        half_set = 1'b0; flag_mask = 8'h00; load_data = 8'h00;
        a8 = '0; b8 = '0; r8 = '0; co8 = 1'b0; a16 = '0; b16 = '0; r16 = '0; co16 = 1'b0;
        mf8 = 8'hFF; ms8 = 8'hFF; mf16 = 8'hFF; ms16 = 8'hFF; mvalid = 1'b0;
        #1;
        test_reset();
        test_numeric();
        test_back_to_back();
        test_exchange();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
